// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the execute-stage divider.
//
// Contents:
//   div_op_e          - funct3[1:0] encodings of DIV, DIVU, REM and REMU
//   div_state_e       - divider sequencer states (IDLE, CALC, FIX)
//   DIV_OVF_DIVIDEND  - most negative 32-bit dividend, the one signed
//                       division input that can overflow (together with -1)
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//
// Ports:
//   rem           in  XLEN  partial remainder before this step
//   dividend_msb  in  1     next dividend bit shifted into the remainder
//   divisor       in  XLEN  divisor magnitude
//   rem_next      out XLEN  partial remainder after this step
//   quot_bit      out 1     quotient bit produced by this step
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            quot_bit
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The bit shifted out of rem acts as an implicit top bit of the shifted
  // remainder, so a set rem MSB means the trial subtraction always fits.
  // The XLEN-bit subtraction then still yields the correct low bits.
  always_comb begin
    shifted  = {rem[XLEN-2:0], dividend_msb};
    diff     = shifted - divisor;
    fits     = rem[XLEN-1] | (shifted >= divisor);
    quot_bit = fits;
    rem_next = fits ? diff : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative XLEN-bit integer divider for RISC-V DIV/DIVU/REM/REMU.
// Restoring algorithm, one quotient bit per cycle, then a sign-fix cycle.
//
// Ports:
//   clk_i     in  1     clock, rising edge
//   rst_i     in  1     synchronous active-high reset
//   start_i   in  1     launch request, sampled only in IDLE
//   op_i      in  2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_i     in  XLEN  dividend, captured with start
//   rs2_i     in  XLEN  divisor, captured with start
//   kill_i    in  1     pipeline flush, aborts any operation in flight
//   busy_o    out 1     high whenever the sequencer is not IDLE
//   done_o    out 1     one-cycle pulse, result_o valid while high
//   result_o  out XLEN  quotient or remainder, held until next completion
//
// Configuration macro DIV_EARLY_OUT_EN: when defined, divide-by-zero and
// signed overflow complete in the launch cycle without entering CALC/FIX.
// When undefined, every operation takes the same XLEN+2 cycles.
module div_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CNT_W     = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  logic [CNT_W-1:0] iter;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] rem;
  logic            want_rem;
  logic            quot_neg;
  logic            rem_neg;
  logic            special;
  logic [XLEN-1:0] special_val;

  div_op_e         op_in;
  logic            op_signed;
  logic            op_rem;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special_in;
  logic [XLEN-1:0] special_val_in;

  logic [XLEN-1:0] step_rem;
  logic            step_bit;
  logic [XLEN-1:0] quot_fixed;
  logic [XLEN-1:0] rem_fixed;
  logic [XLEN-1:0] fix_result;

  assign busy_o = (state != IDLE);

  // Decode the launch operands: magnitudes and signs for signed ops, and
  // the two special cases whose answers are fixed by the ISA. The special
  // result is computed here so FIX (or the early-out path) only selects it.
  // The divide-by-zero remainder is the raw rs1, never its magnitude.
  always_comb begin
    op_in          = div_op_e'(op_i);
    op_signed      = (op_in == OP_DIV) || (op_in == OP_REM);
    op_rem         = (op_in == OP_REM) || (op_in == OP_REMU);
    rs1_neg        = op_signed & rs1_i[XLEN-1];
    rs2_neg        = op_signed & rs2_i[XLEN-1];
    rs1_mag        = rs1_neg ? -rs1_i : rs1_i;
    rs2_mag        = rs2_neg ? -rs2_i : rs2_i;
    div_zero       = (rs2_i == '0);
    div_ovf        = op_signed && (rs1_i == MOST_NEG) && (rs2_i == '1);
    special_in     = div_zero | div_ovf;
    special_val_in = '0;
    if (div_zero) begin
      special_val_in = op_rem ? rs1_i : '1;
    end else if (div_ovf) begin
      special_val_in = op_rem ? '0 : MOST_NEG;
    end
  end

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem          (rem),
    .dividend_msb (dividend[XLEN-1]),
    .divisor      (divisor),
    .rem_next     (step_rem),
    .quot_bit     (step_bit)
  );

  // After CALC the dividend register has been fully replaced by the
  // quotient magnitude; apply the recorded signs, then let a flagged
  // special case override the datapath answer.
  always_comb begin
    quot_fixed = quot_neg ? -dividend : dividend;
    rem_fixed  = rem_neg  ? -rem      : rem;
    fix_result = want_rem ? rem_fixed : quot_fixed;
    if (special) begin
      fix_result = special_val;
    end
  end

  // Sequencer. done_o is a pulse, so it defaults low every cycle. kill_i
  // has priority over everything, including a start in IDLE, and leaves
  // result_o alone; reset additionally clears result_o and all state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      iter        <= '0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      want_rem    <= 1'b0;
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      done_o      <= 1'b0;
      result_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if (kill_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              dividend    <= rs1_mag;
              divisor     <= rs2_mag;
              rem         <= '0;
              iter        <= '0;
              want_rem    <= op_rem;
              quot_neg    <= rs1_neg ^ rs2_neg;
              rem_neg     <= rs1_neg;
              special     <= special_in;
              special_val <= special_val_in;
`ifdef DIV_EARLY_OUT_EN
              if (special_in) begin
                result_o <= special_val_in;
                done_o   <= 1'b1;
              end else begin
                state <= CALC;
              end
`else
              state <= CALC;
`endif
            end
          end
          CALC: begin
            rem      <= step_rem;
            dividend <= {dividend[XLEN-2:0], step_bit};
            iter     <= iter + 1'b1;
            if (iter == LAST_ITER) begin
              state <= FIX;
            end
          end
          FIX: begin
            result_o <= fix_result;
            done_o   <= 1'b1;
            state    <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (XLEN = 32).
// Follows DIV_EARLY_OUT_EN to pick the expected special-case latency.
module tb_div_unit;
  import cpu_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int FULL_LAT = 34;
  localparam int SPEC_LAT = EARLY ? 1 : FULL_LAT;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  div_unit #(
    .XLEN (32)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive a launch during the current cycle N; returns #1 after the edge
  // that samples it, i.e. early in cycle N+1, with start_i dropped.
  task automatic applyStimulus(input div_op_e op, input logic [31:0] a,
                               input logic [31:0] b);
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Count negedges after launch until done_o; lat = k means cycle N+k.
  // Returns -1 if done_o never shows within the bound.
  task automatic waitDone(output int lat, output logic busy_first);
    lat        = -1;
    busy_first = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_i);
      if (i == 1) busy_first = busy_o;
      if (done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input div_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected,
                       input int exp_lat);
    int   lat;
    logic busy_first;
    applyStimulus(op, a, b);
    waitDone(lat, busy_first);
    checkOutput({tag, "_busy"}, {31'b0, busy_first}, {31'b0, exp_lat > 1});
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_res"}, result_o, expected);
  endtask

  initial begin
    int   done_count;
    int   done_lat;
    int   lat;
    logic busy_first;

    rst_i   = 1'b1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    op_i    = 2'b00;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset_done", {31'b0, done_o}, 32'd0);
    checkOutput("reset_res", result_o, 32'd0);

    // Basic unsigned and signed cases
    runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
    @(negedge clk_i);
    checkOutput("done_pulse_width", {31'b0, done_o}, 32'd0);
    checkOutput("result_hold", result_o, 32'd14);
    runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT);
    runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT);
    runOp("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
    runOp("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT);
    runOp("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, FULL_LAT);
    runOp("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, FULL_LAT);
    runOp("div_m20_m3", OP_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, FULL_LAT);

    // Special cases
    runOp("div_by_zero", OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    runOp("rem_by_zero", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678, SPEC_LAT);
    runOp("remneg_by_zero", OP_REM, 32'h8000_0001, 32'd0, 32'h8000_0001, SPEC_LAT);
    runOp("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    runOp("div_ovf", OP_DIV, DIV_OVF_DIVIDEND, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    runOp("rem_ovf", OP_REM, DIV_OVF_DIVIDEND, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);
    runOp("divu_no_ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FULL_LAT);

    // Kill in N+10, restart in N+11
    @(negedge clk_i);
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    #1 kill_i = 1'b1;
    @(posedge clk_i);
    #1 kill_i = 1'b0;
    @(negedge clk_i);
    checkOutput("kill_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("kill_done", {31'b0, done_o}, 32'd0);
    checkOutput("kill_res_held", result_o, 32'd0);
    runOp("after_kill", OP_DIVU, 32'd1001, 32'd7, 32'd143, FULL_LAT);

    // Kill and start together in IDLE: nothing is accepted
    @(negedge clk_i);
    kill_i = 1'b1;
    applyStimulus(OP_DIVU, 32'd9, 32'd3);
    kill_i = 1'b0;
    done_count = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (busy_o || done_o) done_count++;
    end
    checkOutput("kill_start_ignored", 32'(done_count), 32'd0);

    // start_i held high while busy: exactly one completion
    applyStimulus(OP_DIVU, 32'd50, 32'd5);
    start_i = 1'b1;
    rs1_i   = 32'd99;
    done_count = 0;
    done_lat   = -1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk_i);
      if (i == 20) start_i = 1'b0;
      if (done_o) begin
        done_count++;
        done_lat = i;
      end
    end
    checkOutput("held_start_count", 32'(done_count), 32'd1);
    checkOutput("held_start_lat", 32'(done_lat), 32'(FULL_LAT));
    checkOutput("held_start_res", result_o, 32'd10);

    // Back-to-back: second start issued in the done cycle of the first
    runOp("b2b_first", OP_DIVU, 32'd77, 32'd7, 32'd11, FULL_LAT);
    runOp("b2b_second", OP_REMU, 32'd50, 32'd7, 32'd1, FULL_LAT);

    // Reset mid-operation clears the result and aborts
    @(negedge clk_i);
    applyStimulus(OP_DIVU, 32'd9, 32'd3);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    waitDone(lat, busy_first);
    checkOutput("midreset_busy", {31'b0, busy_first}, 32'd0);
    checkOutput("midreset_no_done", 32'(lat), 32'hFFFF_FFFF);
    checkOutput("midreset_res", result_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
